// File: rtl/regfile_read_port_if.sv
// rtl/regfile_read_port_if.sv - read request / response handshake between decode and the register read port
interface regfile_read_port_if #(
   parameter int WIDTH  = 64,
   parameter int ADDR_W = 5
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] ra1;
   logic [ADDR_W-1:0] ra2;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WIDTH-1:0]  rd1;
   logic [WIDTH-1:0]  rd2;

   modport master (
      output req_valid, ra1, ra2, rsp_ready,
      input  req_ready, rsp_valid, rd1, rd2
   );

   modport slave (
      input  req_valid, ra1, ra2, rsp_ready,
      output req_ready, rsp_valid, rd1, rd2
   );
endinterface

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - dual-operand register read with write bypass, zero register and held response
module regfile_read_port #(
   parameter int WIDTH    = 64,
   parameter int NREG     = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREG*WIDTH-1:0] regs_flat,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   regfile_read_port_if.slave    rp
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  rd1_q, rd1_d;
   logic [WIDTH-1:0]  rd2_q, rd2_d;
   logic [ADDR_W-1:0] a1_q, a1_d;
   logic [ADDR_W-1:0] a2_q, a2_d;

   logic             req_ready;
   logic             accept;
   logic             wr_refreshable;
   logic             refresh1;
   logic             refresh2;
   logic [WIDTH-1:0] look1;
   logic [WIDTH-1:0] look2;

   // Zero register and unimplemented addresses win over the bypass.
   function automatic logic [WIDTH-1:0] lookup(
      input logic [ADDR_W-1:0]     a,
      input logic                  we,
      input logic [ADDR_W-1:0]     wa,
      input logic [WIDTH-1:0]      wd,
      input logic [NREG*WIDTH-1:0] regs
   );
      if ((int'(a) == ZERO_REG) || (int'(a) >= NREG)) begin
         return '0;
      end else if (we && (wa == a)) begin
         return wd;
      end else begin
         return regs[int'(a)*WIDTH +: WIDTH];
      end
   endfunction

   assign look1 = lookup(rp.ra1, wr_en, wr_addr, wr_data, regs_flat);
   assign look2 = lookup(rp.ra2, wr_en, wr_addr, wr_data, regs_flat);

   assign req_ready = (state_q == EMPTY) || rp.rsp_ready;
   assign accept    = rp.req_valid && req_ready;

   // A stalled response tracks writes to its held registers so it never goes stale.
   assign wr_refreshable = wr_en && (int'(wr_addr) != ZERO_REG) && (int'(wr_addr) < NREG);
   assign refresh1 = (state_q == FULL) && !rp.rsp_ready && wr_refreshable && (wr_addr == a1_q);
   assign refresh2 = (state_q == FULL) && !rp.rsp_ready && wr_refreshable && (wr_addr == a2_q);

   always_comb begin
      state_d = state_q;
      rd1_d   = rd1_q;
      rd2_d   = rd2_q;
      a1_d    = a1_q;
      a2_d    = a2_q;
      if (accept) begin
         state_d = FULL;
         rd1_d   = look1;
         rd2_d   = look2;
         a1_d    = rp.ra1;
         a2_d    = rp.ra2;
      end else if ((state_q == FULL) && rp.rsp_ready) begin
         state_d = EMPTY;
      end else begin
         if (refresh1) begin
            rd1_d = wr_data;
         end
         if (refresh2) begin
            rd2_d = wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         rd1_q   <= '0;
         rd2_q   <= '0;
         a1_q    <= '0;
         a2_q    <= '0;
      end else begin
         state_q <= state_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         a1_q    <= a1_d;
         a2_q    <= a2_d;
      end
   end

   assign rp.req_ready = req_ready;
   assign rp.rsp_valid = (state_q == FULL);
   assign rp.rd1       = rd1_q;
   assign rp.rd2       = rd2_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// tb/tb_regfile_read_port.sv - randomized and directed checks of regfile_read_port against a register-state model
module tb_regfile_read_port;

   localparam int WIDTH = 64;
   localparam int NREG  = 32;
   localparam int ADDR_W = 5;
   localparam int ZREG  = 31;

   logic                  clk;
   logic                  reset;
   logic [NREG*WIDTH-1:0] regs_flat;
   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic [WIDTH-1:0]      wr_data;

   regfile_read_port_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   regfile_read_port #(
      .WIDTH(WIDTH), .NREG(NREG), .ADDR_W(ADDR_W), .ZERO_REG(ZREG)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .regs_flat (regs_flat),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rp        (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [WIDTH-1:0] regs [NREG];
   always_comb begin
      regs_flat = '0;
      for (int k = 0; k < NREG; k++) regs_flat[k*WIDTH +: WIDTH] = regs[k];
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Model: a valid response always shows the current architectural value of its held addresses.
   logic             m_valid;
   logic [4:0]       m_a1, m_a2;
   logic [WIDTH-1:0] m_last1, m_last2;

   logic             obs_valid, obs_ready;
   logic [WIDTH-1:0] obs_rd1, obs_rd2;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] arch(input logic [4:0] a);
      return (int'(a) == ZREG) ? '0 : regs[a];
   endfunction

   task automatic step(input logic rv, input logic [4:0] a1, input logic [4:0] a2, input logic rr,
                       input logic we, input logic [4:0] wa, input logic [WIDTH-1:0] wd);
      logic exp_ready;
      bus.req_valid = rv;
      bus.ra1       = a1;
      bus.ra2       = a2;
      bus.rsp_ready = rr;
      wr_en         = we;
      wr_addr       = wa;
      wr_data       = wd;
      @(negedge clk);
      obs_valid = bus.rsp_valid;
      obs_ready = bus.req_ready;
      obs_rd1   = bus.rd1;
      obs_rd2   = bus.rd2;
      exp_ready = !m_valid || rr;
      chk("req_ready", {63'd0, bus.req_ready}, {63'd0, exp_ready});
      chk("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, m_valid});
      chk("rd1", bus.rd1, m_valid ? arch(m_a1) : m_last1);
      chk("rd2", bus.rd2, m_valid ? arch(m_a2) : m_last2);
      if (rv && exp_ready) begin
         m_valid = 1'b1;
         m_a1    = a1;
         m_a2    = a2;
      end else if (m_valid && rr) begin
         m_last1 = arch(m_a1);
         m_last2 = arch(m_a2);
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (we) regs[wa] = wd;
   endtask

   function automatic logic [4:0] rnd_addr();
      return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
   endfunction

   int n_seen;

   initial begin
      for (int k = 0; k < NREG; k++) regs[k] = {$urandom, $urandom};
      reset = 1'b0;
      bus.req_valid = 1'b0;
      bus.ra1 = '0;
      bus.ra2 = '0;
      bus.rsp_ready = 1'b0;
      wr_en = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      m_valid = 1'b0;
      m_a1 = '0;
      m_a2 = '0;
      m_last1 = '0;
      m_last2 = '0;
      #2;
      chk("reset_valid", {63'd0, bus.rsp_valid}, 64'd0);
      chk("reset_rd1", bus.rd1, 64'd0);
      chk("reset_rd2", bus.rd2, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Basic read
      regs[3] = 64'h1111;
      regs[7] = 64'h2222;
      step(1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 5'd0, '0);
      step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, '0);
      chk("basic_valid", {63'd0, obs_valid}, 64'd1);
      chk("basic_rd1", obs_rd1, 64'h1111);
      chk("basic_rd2", obs_rd2, 64'h2222);

      // Write bypass, zero register on the other operand
      regs[5] = 64'hAAAA;
      step(1'b1, 5'd5, 5'd31, 1'b1, 1'b1, 5'd5, 64'hBBBB);
      step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, '0);
      chk("bypass_rd1", obs_rd1, 64'hBBBB);
      chk("bypass_rd2", obs_rd2, 64'h0);

      // Zero register ignores writes
      step(1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 64'hFFFF);
      step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, '0);
      chk("zero_rd1", obs_rd1, 64'h0);
      chk("zero_rd2", obs_rd2, 64'h0);

      // Stall refresh; the pending request must not be taken
      regs[9] = 64'h5555;
      regs[4] = 64'h4444;
      step(1'b1, 5'd9, 5'd4, 1'b1, 1'b0, 5'd0, '0);
      step(1'b1, 5'd12, 5'd13, 1'b0, 1'b1, 5'd9, 64'h1234);
      chk("stall_ready", {63'd0, obs_ready}, 64'd0);
      chk("stall_rd1_before", obs_rd1, 64'h5555);
      step(1'b1, 5'd12, 5'd13, 1'b0, 1'b0, 5'd0, '0);
      chk("stall_ready2", {63'd0, obs_ready}, 64'd0);
      chk("refresh_rd1", obs_rd1, 64'h1234);
      chk("refresh_rd2_held", obs_rd2, 64'h4444);
      step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, '0);

      // Throughput: eight back-to-back requests, no bubbles
      n_seen = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 5'(i), 5'(i + 8), 1'b1, 1'b0, 5'd0, '0);
         if (i > 0) begin
            if (obs_valid) n_seen++;
            chk("tput_rd1", obs_rd1, regs[i-1]);
         end
      end
      step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, '0);
      if (obs_valid) n_seen++;
      chk("tput_rd1_last", obs_rd1, regs[7]);
      chk("tput_count", 64'(n_seen), 64'd8);

      // Reset mid-response
      step(1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 5'd0, '0);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      reset = 1'b0;
      #1;
      chk("midreset_valid", {63'd0, bus.rsp_valid}, 64'd0);
      chk("midreset_rd1", bus.rd1, 64'd0);
      chk("midreset_rd2", bus.rd2, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("postreset_ready", {63'd0, bus.req_ready}, 64'd1);
      m_valid = 1'b0;
      m_last1 = '0;
      m_last2 = '0;
      @(posedge clk);
      #1;

      // Randomized traffic with backpressure and writes aimed at held addresses
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), ($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 1)), rnd_addr(), {$urandom, $urandom});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
